// File: rtl/kbd_panel.sv
// kbd_panel: PS/2 keyboard receiver, 8-digit seven-segment readout and 16-LED running light.
// Optional build macro PS2_PARITY_CHECK_EN: when defined, frames with bad odd parity are
// rejected and counted as errors; otherwise the parity bit is ignored.
module kbd_panel #(
    parameter int unsigned LIGHT_PERIOD  = 5_000_000,
    parameter int unsigned FRAME_TIMEOUT = 100_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] ledr,
    output logic [7:0]  seg0,
    output logic [7:0]  seg1,
    output logic [7:0]  seg2,
    output logic [7:0]  seg3,
    output logic [7:0]  seg4,
    output logic [7:0]  seg5,
    output logic [7:0]  seg6,
    output logic [7:0]  seg7
);

    localparam int unsigned LW = $clog2(LIGHT_PERIOD);
    localparam int unsigned TW = $clog2(FRAME_TIMEOUT + 1);

    localparam logic [7:0] Blank = 8'hFF;

    logic [LW-1:0] light_cnt_q;
    logic          light_tc;

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          clk_hist_q;
    logic          fall;
    logic          data_bit;

    logic [3:0]    bit_cnt_q;
    logic [9:0]    frame_q;
    logic [TW-1:0] idle_q;
    logic          timeout;
    logic [3:0]    bit_idx;
    logic          frame_done;
    logic          frame_ok;
    logic [7:0]    rx_byte;

    logic          brk_q;
    logic          held_q;
    logic [7:0]    cur_code_q;
    logic [7:0]    press_cnt_q;
    logic [7:0]    err_cnt_q;

    function automatic logic [7:0] hex_glyph(input logic [3:0] n);
        logic [7:0] g;
        unique case (n)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            4'hF: g = 8'h8E;
        endcase
        return g;
    endfunction

    assign light_tc = (light_cnt_q == LW'(LIGHT_PERIOD - 1));

    // Running light: rotate left once per LIGHT_PERIOD cycles.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            light_cnt_q <= '0;
            ledr        <= 16'h0001;
        end else if (light_tc) begin
            light_cnt_q <= '0;
            ledr        <= {ledr[14:0], ledr[15]};
        end else begin
            light_cnt_q <= light_cnt_q + 1'b1;
        end
    end

    // Two-flop synchronisers for both pins plus a history flop for clock edge detection.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_hist_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            clk_hist_q <= clk_sync_q[1];
        end
    end

    assign fall     = clk_hist_q & ~clk_sync_q[1];
    assign data_bit = dat_sync_q[1];

    // A stalled partial frame is abandoned; an edge arriving in the same cycle starts afresh.
    assign timeout    = (bit_cnt_q != 4'd0) && (idle_q == TW'(FRAME_TIMEOUT - 1));
    assign bit_idx    = timeout ? 4'd0 : bit_cnt_q;
    assign frame_done = fall && (bit_idx == 4'd10);
    assign rx_byte    = frame_q[8:1];

    // frame_q holds bits 0..9 (start, data, parity); the stop bit is judged live.
    always_comb begin
`ifdef PS2_PARITY_CHECK_EN
        frame_ok = ~frame_q[0] & data_bit & (^frame_q[9:1]);
`else
        frame_ok = ~frame_q[0] & data_bit;
`endif
    end

    // Bit counter, shift register and mid-frame idle timer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bit_cnt_q <= 4'd0;
            frame_q   <= '0;
            idle_q    <= '0;
        end else begin
            if (fall) begin
                frame_q   <= {data_bit, frame_q[9:1]};
                bit_cnt_q <= (bit_idx == 4'd10) ? 4'd0 : bit_idx + 4'd1;
            end else if (timeout) begin
                bit_cnt_q <= 4'd0;
            end
            if (fall || bit_cnt_q == 4'd0) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + 1'b1;
            end
        end
    end

    // Scan-code decoder and error counter, updated when the stop bit is sampled.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            brk_q       <= 1'b0;
            held_q      <= 1'b0;
            cur_code_q  <= 8'h00;
            press_cnt_q <= 8'h00;
            err_cnt_q   <= 8'h00;
        end else if (frame_done) begin
            if (!frame_ok) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end else if (rx_byte == 8'hE0) begin
                // Extended prefix carries no information for this display.
            end else if (rx_byte == 8'hF0) begin
                brk_q <= 1'b1;
            end else if (brk_q) begin
                brk_q  <= 1'b0;
                held_q <= 1'b0;
            end else begin
                cur_code_q <= rx_byte;
                if (!held_q) begin
                    held_q      <= 1'b1;
                    press_cnt_q <= press_cnt_q + 8'd1;
                end
            end
        end
    end

    // Digit patterns straight from the registers.
    always_comb begin
        seg0 = held_q ? hex_glyph(cur_code_q[3:0]) : Blank;
        seg1 = held_q ? hex_glyph(cur_code_q[7:4]) : Blank;
        seg2 = Blank;
        seg3 = Blank;
        seg4 = hex_glyph(press_cnt_q[3:0]);
        seg5 = hex_glyph(press_cnt_q[7:4]);
        seg6 = hex_glyph(err_cnt_q[3:0]);
        seg7 = hex_glyph(err_cnt_q[7:4]);
    end

endmodule

// File: tb/tb_kbd_panel.sv
// Bench for kbd_panel: directed test-plan cases then randomized frames against a byte-level model.
module tb_kbd_panel;

    localparam int unsigned LightPeriod  = 4;
    localparam int unsigned FrameTimeout = 200;
    localparam int          HalfBit      = 20;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] ledr;
    logic [7:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

    kbd_panel #(
        .LIGHT_PERIOD (LightPeriod),
        .FRAME_TIMEOUT(FrameTimeout)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .ledr    (ledr),
        .seg0    (seg0),
        .seg1    (seg1),
        .seg2    (seg2),
        .seg3    (seg3),
        .seg4    (seg4),
        .seg5    (seg5),
        .seg6    (seg6),
        .seg7    (seg7)
    );

    always #5 clk = ~clk;

    // Cycles since reset release, for the light model.
    int cyc = 0;
    always @(posedge clk) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model state.
    bit       m_brk, m_held;
    bit [7:0] m_cur, m_press, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_brk = 0; m_held = 0; m_cur = 0; m_press = 0; m_err = 0;
    endtask

    task automatic model_frame(input bit [10:0] bits);
        bit [7:0] b;
        bit ok;
        b  = bits[8:1];
        ok = (bits[0] == 1'b0) && (bits[10] == 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        ok = ok && ($countones(bits[9:1]) % 2 == 1);
`endif
        if (!ok) m_err++;
        else if (b == 8'hE0) ;
        else if (b == 8'hF0) m_brk = 1;
        else if (m_brk) begin
            m_brk = 0; m_held = 0;
        end else begin
            m_cur = b;
            if (!m_held) begin
                m_held = 1; m_press++;
            end
        end
    endtask

    function automatic bit [10:0] make_bits(input bit [7:0] b, input bit bad_par,
                                            input bit bad_start, input bit bad_stop);
        bit par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, bad_start};
    endfunction

    task automatic send_bits(input bit [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cyc(HalfBit / 2);
            ps2_clk = 1'b0;
            wait_cyc(HalfBit);
            ps2_clk = 1'b1;
            wait_cyc(HalfBit / 2);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input bit [7:0] b, input bit bad_par, input bit bad_start,
                              input bit bad_stop);
        bit [10:0] bits;
        bits = make_bits(b, bad_par, bad_start, bad_stop);
        send_bits(bits, 11);
        model_frame(bits);
        wait_cyc(20);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".seg0"}, seg0, m_held ? glyph[m_cur[3:0]] : 8'hFF);
        check({tag, ".seg1"}, seg1, m_held ? glyph[m_cur[7:4]] : 8'hFF);
        check({tag, ".seg2"}, seg2, 8'hFF);
        check({tag, ".seg3"}, seg3, 8'hFF);
        check({tag, ".seg4"}, seg4, glyph[m_press[3:0]]);
        check({tag, ".seg5"}, seg5, glyph[m_press[7:4]]);
        check({tag, ".seg6"}, seg6, glyph[m_err[3:0]]);
        check({tag, ".seg7"}, seg7, glyph[m_err[7:4]]);
        check({tag, ".ledr"}, ledr, 16'(32'h1 << ((cyc / LightPeriod) % 16)));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        wait_cyc(2);
        resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        wait_cyc(4);
        check("light_first", ledr, 16'h0002);
        check("reset_seg0", seg0, 8'hFF);
        check("reset_seg4", seg4, 8'hC0);
        check("reset_seg7", seg7, 8'hC0);
        wait_cyc(60);
        check("light_wrap", ledr, 16'h0001);
        wait_cyc(6);
        check_all("reset");

        send_frame(8'h1C, 0, 0, 0);
        check("make_seg1", seg1, 8'hF9);
        check("make_seg0", seg0, 8'hC6);
        check("make_seg4", seg4, 8'hF9);
        check_all("make");
        send_frame(8'h1C, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
        check("repeat_seg4", seg4, 8'hF9);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
        check("release_seg0", seg0, 8'hFF);
        check_all("release");

        send_frame(8'h1C, 1, 0, 0);
        check_all("bad_parity");
        send_frame(8'h1C, 0, 1, 0);
        check_all("bad_start");
        send_frame(8'h1C, 0, 0, 1);
        check_all("bad_stop");

        // Partial frame abandoned by timeout, then a clean frame.
        send_bits(make_bits(8'h55, 0, 0, 0), 5);
        wait_cyc(FrameTimeout + 50);
        send_frame(8'h32, 0, 0, 0);
        check_all("timeout");

        // Reset mid-frame discards the partial frame.
        send_bits(make_bits(8'h21, 0, 0, 0), 5);
        do_reset();
        wait_cyc(3);
        check_all("reset_mid");
        send_frame(8'h2B, 0, 0, 0);
        check_all("after_reset");

        for (int it = 0; it < 40; it++) begin
            int kind;
            bit [7:0] b;
            kind = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'($urandom);
                default: b = m_cur;
            endcase
            if (kind == 0) begin
                send_bits(make_bits(b, 0, 0, 0), $urandom_range(1, 10));
                wait_cyc(FrameTimeout + 50);
            end else begin
                send_frame(b, kind == 1, kind == 2, kind == 3);
            end
            check_all($sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
